// File: rtl/npu_mem_pkg.sv
// Shared definitions for the scratchpad memory subsystem: default bus widths
// and the read-stage FSM state encoding.
package npu_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // A tile with either dimension zero issues no reads at all.
    function automatic logic tile_is_empty(input logic [CNT_W_DEF-1:0] cols,
                                           input logic [CNT_W_DEF-1:0] rows);
        return (cols == {CNT_W_DEF{1'b0}}) || (rows == {CNT_W_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// 2-D tile address walker: column/row counters, row base and the registered
// read address, plus end-of-row / end-of-tile flags for the current address.
module tile_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [CNT_WIDTH-1:0]  cols_i,
    input  logic [CNT_WIDTH-1:0]  rows_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic                  adv_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  eol_o,
    output logic                  last_o
);

    logic [CNT_WIDTH-1:0]  cols_q,     cols_d;
    logic [CNT_WIDTH-1:0]  rows_q,     rows_d;
    logic [ADDR_WIDTH-1:0] stride_q,   stride_d;
    logic [CNT_WIDTH-1:0]  col_cnt_q,  col_cnt_d;
    logic [CNT_WIDTH-1:0]  row_cnt_q,  row_cnt_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [ADDR_WIDTH-1:0] next_row_s;
    logic                  eol_s;
    logic                  last_s;

    // Flags describe the word at the current address; sums wrap naturally.
    always_comb begin
        eol_s      = (col_cnt_q == (cols_q - CNT_WIDTH'(1)));
        last_s     = eol_s && (row_cnt_q == (rows_q - CNT_WIDTH'(1)));
        next_row_s = row_base_q + stride_q;
    end

    // Next-state for the walker: command load takes priority over advancing.
    always_comb begin
        cols_d     = cols_q;
        rows_d     = rows_q;
        stride_d   = stride_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load_i) begin
            cols_d     = cols_i;
            rows_d     = rows_i;
            stride_d   = stride_i;
            col_cnt_d  = {CNT_WIDTH{1'b0}};
            row_cnt_d  = {CNT_WIDTH{1'b0}};
            row_base_d = base_i;
            addr_d     = base_i;
        end else if (adv_i) begin
            if (eol_s) begin
                col_cnt_d  = {CNT_WIDTH{1'b0}};
                row_cnt_d  = row_cnt_q + CNT_WIDTH'(1);
                row_base_d = next_row_s;
                addr_d     = next_row_s;
            end else begin
                col_cnt_d  = col_cnt_q + CNT_WIDTH'(1);
                addr_d     = addr_q + ADDR_WIDTH'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q     <= {CNT_WIDTH{1'b0}};
            rows_q     <= {CNT_WIDTH{1'b0}};
            stride_q   <= {ADDR_WIDTH{1'b0}};
            col_cnt_q  <= {CNT_WIDTH{1'b0}};
            row_cnt_q  <= {CNT_WIDTH{1'b0}};
            row_base_q <= {ADDR_WIDTH{1'b0}};
            addr_q     <= {ADDR_WIDTH{1'b0}};
        end else begin
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign raddr_o = addr_q;
    assign eol_o   = eol_s;
    assign last_o  = last_s;

endmodule

// File: rtl/mem_tile_reader.sv
// Scratchpad read stage: walks a 2-D tile through the combinational read port
// and presents the words as a valid/ready stream with row and tile markers.
module mem_tile_reader
    import npu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [CNT_WIDTH-1:0]  cols_i,
    input  logic [CNT_WIDTH-1:0]  rows_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  ren_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_eol_o,
    output logic                  m_last_o
);

    rd_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_eol_q, m_eol_d;
    logic                  m_last_q, m_last_d;
    logic                  ren_s;
    logic                  hs_s;
    logic                  load_s;
    logic                  empty_s;
    logic                  ag_eol_s;
    logic                  ag_last_s;

    // Read issue is gated by output-stage occupancy, so a stall costs no reads.
    always_comb begin
        ren_s   = (state_q == ST_RUN) && (!m_valid_q || m_ready_i);
        hs_s    = m_valid_q && m_ready_i;
        load_s  = (state_q == ST_IDLE) && start_i;
        empty_s = (cols_i == {CNT_WIDTH{1'b0}}) || (rows_i == {CNT_WIDTH{1'b0}});
    end

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_s),
        .base_i   (base_i),
        .cols_i   (cols_i),
        .rows_i   (rows_i),
        .stride_i (stride_i),
        .adv_i    (ren_s),
        .raddr_o  (raddr_o),
        .eol_o    (ag_eol_s),
        .last_o   (ag_last_s)
    );

    // FSM next-state plus the done pulse and registered busy flag.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_s && empty_s) begin
                    done_d = 1'b1;
                end else if (load_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ren_s && ag_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (hs_s && m_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Single output register: load on read, clear on handshake, else hold.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_eol_d   = m_eol_q;
        m_last_d  = m_last_q;
        if (ren_s) begin
            m_valid_d = 1'b1;
            m_data_d  = rdata_i;
            m_eol_d   = ag_eol_s;
            m_last_d  = ag_last_s;
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Control and output-stage registers; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {DATA_WIDTH{1'b0}};
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_eol_q   <= m_eol_d;
            m_last_q  <= m_last_d;
        end
    end

    assign ren_o     = ren_s;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_eol_o   = m_eol_q;
    assign m_last_o  = m_last_q;

endmodule

// File: doc/mem_tile_reader.md
# mem_tile_reader

Read-side stage for the on-chip scratchpad memory. On a start command it walks a 2-D tile (rows × cols, programmable row stride) through the memory's read port. It returns the words as a valid/ready stream with row and tile markers, feeding the downstream compute array. The memory read is combinational (data valid in the same cycle as address/enable). This block registers that data into a single output stage and throttles reads under backpressure.

## Interface
- ADDR_WIDTH, 10, memory address width; all address arithmetic is modulo 2^ADDR_WIDTH
- DATA_WIDTH, 16, memory word width
- CNT_WIDTH, 10, width of row/column counts
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  command pulse; accepted only in IDLE
- base_i  in  ADDR_WIDTH  tile start address
- cols_i  in  CNT_WIDTH  words per row
- rows_i  in  CNT_WIDTH  row count
- stride_i  in  ADDR_WIDTH  address increment between row starts
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- raddr_o  out  ADDR_WIDTH  memory read address (registered)
- ren_o  out  1  memory read enable
- rdata_i  in  DATA_WIDTH  memory read data, valid same cycle as ren_o/raddr_o
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream accepts beat
- m_data_o  out  DATA_WIDTH  output word
- m_eol_o  out  1  beat is last of a row
- m_last_o  out  1  beat is last of the tile

## Operation
- Uses a three-state FSM: IDLE, RUN, DRAIN.
- IDLE:
  - On start_i, latch cols, rows and stride.
  - Load the address register with base_i; clear col_cnt and row_cnt.
  - If cols_i==0 or rows_i==0: no reads are issued. Stay in IDLE and pulse done_o next cycle.
  - Otherwise go to RUN.
- RUN, read issue:
  - ren_o = (state==RUN) && (!m_valid_o || m_ready_i). This is combinational on m_ready_i.
  - When ren_o=1, capture rdata_i into m_data_o, set m_valid_o, and set eol/last flags for that word.
- RUN, address walk (on each issued read):
  - Not last column: col_cnt+1 and addr+1.
  - Last column: col_cnt←0, row_cnt+1, row_base←row_base+stride, addr←new row_base.
  - All address sums wrap modulo 2^ADDR_WIDTH.
- RUN → DRAIN once the last word (row rows−1, col cols−1) is issued.
- DRAIN:
  - ren_o=0.
  - On handshake of the beat with m_last_o=1, return to IDLE and pulse done_o in the following cycle.
- Output stage:
  - m_valid_o clears on handshake when no new read is issued that cycle.
  - m_data_o and the flags are stable while m_valid_o && !m_ready_i.
- start_i is ignored while busy_o=1; no queueing.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Asynchronous reset mid-tile abandons the tile immediately:
  - No done_o.
  - The partially read beat is discarded (m_valid_o=0).
- Cycle 0: start_i sampled.
- Cycles 1..N: RUN issues one read per cycle while unstalled.
- The first m_valid_o appears in cycle 2. The beat for read k is presented in the cycle after that read.
- Throughput is 1 beat/cycle with m_ready_i held high; zero-bubble under continuous ready.
- busy_o is 1 in RUN and DRAIN, and 0 in the done_o cycle.
- With m_ready_i high, done_o asserts N+2 cycles after start for an N-word tile.
- In a zero-size tile, done_o asserts at cycle 1.

## Structure
- Shared package npu_mem_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - Default ADDR/DATA/CNT widths, shared with the memory block.
- Natural sub-module: tile_addr_gen.
  - Holds col/row counters, row_base and address register.
  - Takes an advance input; produces raddr and the eol/last flags of the current address.
- The top level holds the FSM and the output register stage.

## Test plan
- Basic 2-D walk: base=0, cols=3, rows=2, stride=4, m_ready_i=1.
  - raddr sequence 0,1,2,4,5,6.
  - Six beats with the memory contents; eol on beats 3 and 6, last on beat 6.
  - done_o at cycle 8.
- Backpressure: same tile, m_ready_i low for beats 2–4 (3 cycles).
  - ren_o=0 during the stall; beat 2 data held stable.
  - No beat lost or duplicated; done delayed by exactly 3 cycles.
- Wrap: base=1022, cols=4, rows=1.
  - raddr 1022,1023,0,1; last on the 4th beat.
- Zero size: cols=0, rows=5.
  - No ren_o, no m_valid_o; done_o at cycle 1; busy_o never high.
- Start while busy: second start_i mid-tile with a different base.
  - Ignored; the original sequence completes with a single done_o.
- Reset mid-tile: assert rst_n low after beat 2.
  - All outputs 0 immediately.
  - A new start after release reads from the new base correctly.
